// File: rtl/rom_mp_pkg.sv
// Shared definitions for the multi-channel lookup ROM: default widths,
// the response record and the ROM content function.
package rom_mp_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int NCH_DEF    = 2;
  localparam int ID_W_DEF   = 1;

  // Response record at the default widths; rom_mp carries the same
  // field order at its own parameterised widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ID_W_DEF-1:0]   id;
    logic                  err;
  } rsp_t;

  // Identity map, except that addresses ending in 5'b11000 read back
  // with bit 3 cleared (i.e. a-8). Callers truncate to DATA_W.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = a;
    if (a[4:0] == 5'b11000) w[3] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the
// pointer (with wrap). The pointer moves past the winner only when the
// caller reports that the grant was actually used (adv_i).
module rr_arbiter
  import rom_mp_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gidx_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Search upward from the pointer for the first active request.
  always_comb begin
    gnt_o  = '0;
    gidx_o = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % N]) begin
        found  = 1'b1;
        gidx_o = PW'((int'(ptr_q) + i) % N);
      end
    end
    if (found) gnt_o[gidx_o] = 1'b1;
  end

  // Next pointer is one past the winner, wrapping at N.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = (int'(gidx_o) == N - 1) ? '0 : PW'(int'(gidx_o) + 1);
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rom_mp.sv
// Multi-channel lookup ROM: NCH requesters share one ROM via a
// round-robin arbiter; results land in a 2-entry FIFO tagged with the
// channel id and an out-of-range flag.
module rom_mp
  import rom_mp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_err
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Parameterised form of rsp_t.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              err;
  } ent_t;

  logic [NCH-1:0]    gnt;
  logic [PW-1:0]     gidx;
  logic              space, push, pop;
  logic [ADDR_W-1:0] sel_addr;
  ent_t              push_ent;
  ent_t              mem_q [2];
  logic              rd_q, wr_q;
  logic [1:0]        cnt_q, cnt_d;

  rr_arbiter #(.N(NCH), .PW(PW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req_valid),
    .adv_i  (push),
    .gnt_o  (gnt),
    .gidx_o (gidx)
  );

  assign rsp_valid = (cnt_q != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  // A full FIFO still has room when the head leaves this same cycle.
  assign space     = (cnt_q < 2'd2) | pop;

  // Ready is forced low during reset so nothing is accepted mid-clear.
  always_comb begin
    req_ready = '0;
    if (!rst && space) req_ready = gnt;
  end

  assign push = |req_ready;

  // Look up the granted channel's address and build the FIFO entry.
  always_comb begin
    sel_addr     = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    push_ent     = '0;
    push_ent.id  = ID_W'(gidx);
    push_ent.err = (int'({1'b0, sel_addr}) >= DEPTH);
    if (!push_ent.err) push_ent.data = DATA_W'(rom_word(32'(sel_addr)));
  end

  // Occupancy next state; push+pop together leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_ent;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

  assign rsp_data = mem_q[rd_q].data;
  assign rsp_id   = mem_q[rd_q].id;
  assign rsp_err  = mem_q[rd_q].err;

endmodule
